// File: rtl/dbus_addr_demux.sv
// ----------------------------------------------------------------------------
// dbus_addr_demux
// Demultiplexes the CPU data-memory port onto N_SLV slaves. Each accepted
// request is decoded against per-slave base/size windows, forwarded to exactly
// one slave, and its target is recorded in an in-order FIFO. Responses are
// returned to the master in issue order. Unmapped requests are answered
// locally with an error response.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   data_req_i/gnt_o      master handshake (gnt is combinational)
//   data_we/be/addr/wdata master request payload
//   data_rvalid/rdata/err registered response to the master
//   slv_req_o             one-hot per-slave request (combinational)
//   slv_we/be/addr/wdata  broadcast payload (combinational pass-through)
//   slv_rvalid_i          per-slave response valid
//   slv_rdata_i           packed per-slave read data
//   outst_o               registered FIFO occupancy
//   proto_err_o           sticky flag: response from a slave that is not head
//
// Build option
//   DBUS_TIMEOUT_EN : adds a response watchdog. A slave head entry waiting
//                     TIMEOUT_CYC cycles is popped with an error response.
// ----------------------------------------------------------------------------
module dbus_addr_demux #(
   parameter int unsigned           N_SLV       = 3,
   parameter int unsigned           AW          = 32,
   parameter int unsigned           DW          = 32,
   parameter int unsigned           SW          = DW / 8,
   parameter logic [N_SLV*AW-1:0]   SLV_BASE    = {32'h800C, 32'h8000, 32'h4000},
   parameter logic [N_SLV*AW-1:0]   SLV_SIZE    = {32'h14, 32'hC, 32'h4000},
   parameter int unsigned           MAX_OUTST   = 2,
   parameter int unsigned           TIMEOUT_CYC = 256
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   // master port
   input  logic                        data_req_i,
   output logic                        data_gnt_o,
   input  logic                        data_we_i,
   input  logic [SW-1:0]               data_be_i,
   input  logic [AW-1:0]               data_addr_i,
   input  logic [DW-1:0]               data_wdata_i,
   output logic                        data_rvalid_o,
   output logic [DW-1:0]               data_rdata_o,
   output logic                        data_err_o,
   // slave ports
   output logic [N_SLV-1:0]            slv_req_o,
   output logic                        slv_we_o,
   output logic [SW-1:0]               slv_be_o,
   output logic [AW-1:0]               slv_addr_o,
   output logic [DW-1:0]               slv_wdata_o,
   input  logic [N_SLV-1:0]            slv_rvalid_i,
   input  logic [N_SLV*DW-1:0]         slv_rdata_i,
   // status
   output logic [$clog2(MAX_OUTST):0]  outst_o,
   output logic                        proto_err_o
);

   // target index width; value N_SLV encodes an unmapped (MISS) entry
   localparam int unsigned IW       = $clog2(N_SLV + 1);
   localparam int unsigned PW       = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned CW       = $clog2(MAX_OUTST) + 1;
   localparam logic [IW-1:0] MISS_IDX = IW'(N_SLV);

   // elaboration-time parameter sanity check
   if (N_SLV < 1 || N_SLV > 8 || MAX_OUTST < 1 ||
       (MAX_OUTST & (MAX_OUTST - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("dbus_addr_demux: illegal parameter set");
   end

   // ------------------------------------------------------------------------
   // state
   // ------------------------------------------------------------------------
   logic [IW-1:0]  fifo_q [MAX_OUTST];
   logic [IW-1:0]  fifo_d [MAX_OUTST];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           rvalid_q, rvalid_d;
   logic [DW-1:0]  rdata_q, rdata_d;
   logic           err_q, err_d;
   logic           proto_q, proto_d;

   // ------------------------------------------------------------------------
   // combinational helpers
   // ------------------------------------------------------------------------
   logic [N_SLV-1:0] hit_c;
   logic [IW-1:0]    dec_idx_c;
   logic             full_c;
   logic             empty_c;
   logic             push_c;
   logic             pop_c;
   logic [IW-1:0]    head_idx_c;
   logic [N_SLV-1:0] head_oh_c;
   logic             head_miss_c;
   logic             head_hit_c;
   logic             viol_c;
   logic [DW-1:0]    head_rdata_c;
   logic             wdog_fire_c;

   // Window decode; the upper limit is formed at AW+1 bits so a window ending
   // at the top of the address space does not wrap to zero.
   for (genvar k = 0; k < N_SLV; k++) begin : g_dec
      logic [AW:0] base_x;
      logic [AW:0] lim_x;
      assign base_x   = {1'b0, SLV_BASE[k*AW +: AW]};
      assign lim_x    = base_x + {1'b0, SLV_SIZE[k*AW +: AW]};
      assign hit_c[k] = ({1'b0, data_addr_i} >= base_x) &&
                        ({1'b0, data_addr_i} <  lim_x);
   end

   // Overlapping windows resolve to the lowest slave index.
   always_comb begin
      dec_idx_c = MISS_IDX;
      for (int k = int'(N_SLV) - 1; k >= 0; k--) begin
         if (hit_c[k]) begin
            dec_idx_c = IW'(k);
         end
      end
   end

   // Request side
   assign full_c      = (cnt_q == CW'(MAX_OUTST));
   assign empty_c     = (cnt_q == '0);
   assign data_gnt_o  = data_req_i && !full_c;
   assign push_c      = data_gnt_o;

   for (genvar k = 0; k < N_SLV; k++) begin : g_req
      assign slv_req_o[k] = push_c && (dec_idx_c == IW'(k));
      assign head_oh_c[k] = !empty_c && (head_idx_c == IW'(k));
   end

   assign slv_we_o    = data_we_i;
   assign slv_be_o    = data_be_i;
   assign slv_addr_o  = data_addr_i;
   assign slv_wdata_o = data_wdata_i;

   // Response side: only the slave recorded at the FIFO head may answer.
   assign head_idx_c  = fifo_q[rd_ptr_q];
   assign head_miss_c = !empty_c && (head_idx_c == MISS_IDX);
   assign head_hit_c  = |(slv_rvalid_i & head_oh_c);
   assign viol_c      = |(slv_rvalid_i & ~head_oh_c);
   assign pop_c       = head_hit_c || head_miss_c || wdog_fire_c;

   always_comb begin
      head_rdata_c = '0;
      for (int unsigned k = 0; k < N_SLV; k++) begin
         if (head_oh_c[k]) begin
            head_rdata_c = slv_rdata_i[k*DW +: DW];
         end
      end
   end

   // ------------------------------------------------------------------------
   // optional response watchdog
   // ------------------------------------------------------------------------
`ifdef DBUS_TIMEOUT_EN
   localparam int unsigned TW  = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned TW1 = TW + 1;

   logic [TW-1:0] wdog_q, wdog_d;
   logic          wdog_wait_c;

   // counting only while a real slave owns the head and has not answered
   assign wdog_wait_c = (|head_oh_c) && !head_hit_c;
   assign wdog_fire_c = wdog_wait_c &&
                        ((TW1'(wdog_q) + TW1'(1)) == TW1'(TIMEOUT_CYC));

   always_comb begin
      wdog_d = wdog_q;
      if (pop_c || empty_c) begin
         wdog_d = '0;
      end else if (wdog_wait_c) begin
         wdog_d = wdog_q + TW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign wdog_fire_c = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + CW'(push_c) - CW'(pop_c);
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      err_d    = err_q;
      proto_d  = proto_q | viol_c;

      if (push_c) begin
         fifo_d[wr_ptr_q] = dec_idx_c;
         wr_ptr_d = (wr_ptr_q == PW'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + PW'(1);
      end

      if (pop_c) begin
         rd_ptr_d = (rd_ptr_q == PW'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + PW'(1);
      end

      // a slave answer takes precedence; otherwise MISS or watchdog error
      if (head_hit_c) begin
         rvalid_d = 1'b1;
         rdata_d  = head_rdata_c;
         err_d    = 1'b0;
      end else if (head_miss_c || wdog_fire_c) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         err_d    = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         proto_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         proto_q  <= proto_d;
      end
   end

   // FIFO storage needs no reset: occupancy and pointers define validity
   always_ff @(posedge clk_i) begin
      fifo_q <= fifo_d;
   end

   assign data_rvalid_o = rvalid_q;
   assign data_rdata_o  = rdata_q;
   assign data_err_o    = err_q;
   assign outst_o       = cnt_q;
   assign proto_err_o   = proto_q;

endmodule

// File: tb/tb_dbus_addr_demux.sv
// Testbench for dbus_addr_demux: table of decode/response vectors, hand-built
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_dbus_addr_demux;

   localparam int N_SLV       = 3;
   localparam int AW          = 32;
   localparam int DW          = 32;
   localparam int SW          = 4;
   localparam int MAX_OUTST   = 2;
   localparam int TIMEOUT_CYC = 256;
   localparam int MISS        = N_SLV;

   localparam logic [AW-1:0] BASE [N_SLV] = '{32'h4000, 32'h8000, 32'h800C};
   localparam logic [AW-1:0] SIZE [N_SLV] = '{32'h4000, 32'h000C, 32'h0014};

   logic                 clk_i = 1'b0;
   logic                 rst_i;
   logic                 data_req_i;
   logic                 data_gnt_o;
   logic                 data_we_i;
   logic [SW-1:0]        data_be_i;
   logic [AW-1:0]        data_addr_i;
   logic [DW-1:0]        data_wdata_i;
   logic                 data_rvalid_o;
   logic [DW-1:0]        data_rdata_o;
   logic                 data_err_o;
   logic [N_SLV-1:0]     slv_req_o;
   logic                 slv_we_o;
   logic [SW-1:0]        slv_be_o;
   logic [AW-1:0]        slv_addr_o;
   logic [DW-1:0]        slv_wdata_o;
   logic [N_SLV-1:0]     slv_rvalid_i;
   logic [N_SLV*DW-1:0]  slv_rdata_i;
   logic [1:0]           outst_o;
   logic                 proto_err_o;

   dbus_addr_demux #(
      .N_SLV(N_SLV), .AW(AW), .DW(DW), .SW(SW),
      .SLV_BASE({32'h800C, 32'h8000, 32'h4000}),
      .SLV_SIZE({32'h14, 32'hC, 32'h4000}),
      .MAX_OUTST(MAX_OUTST), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
      .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
      .slv_req_o(slv_req_o), .slv_we_o(slv_we_o), .slv_be_o(slv_be_o),
      .slv_addr_o(slv_addr_o), .slv_wdata_o(slv_wdata_o),
      .slv_rvalid_i(slv_rvalid_i), .slv_rdata_i(slv_rdata_i),
      .outst_o(outst_o), .proto_err_o(proto_err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_vec = 0;
   int n_err = 0;

   // model state: outstanding targets in issue order, plus expected response
   int             mq[$];
   logic           e_rvalid;
   logic [DW-1:0]  e_rdata;
   logic           e_err;
   logic           e_proto;
`ifdef DBUS_TIMEOUT_EN
   int             wdog;
`endif

   // observations from the latest cycle
   logic             obs_gnt;
   logic [N_SLV-1:0] obs_sreq;
   logic             obs_rvalid;
   logic [DW-1:0]    obs_rdata;
   logic             obs_err;
   logic             obs_proto;
   logic [1:0]       obs_outst;

   typedef struct {
      logic [AW-1:0]    addr;
      logic             we;
      logic [N_SLV-1:0] exp_req;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // address -> slave index by window arithmetic; lowest index wins
   function automatic int ref_decode(input logic [AW-1:0] a);
      longint unsigned x, lo, hi;
      x = 64'(a);
      for (int k = 0; k < N_SLV; k++) begin
         lo = 64'(BASE[k]);
         hi = lo + 64'(SIZE[k]);
         if (x >= lo && x < hi) return k;
      end
      return MISS;
   endfunction

   // one clock: drive, check combinational outputs, advance model, clock, check registers
   task automatic run_cycle(input logic req, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic [SW-1:0] be,
                            input logic [N_SLV-1:0] rv, input logic [N_SLV*DW-1:0] rd);
      int               tgt;
      logic             e_gnt;
      logic [N_SLV-1:0] e_sreq;
      logic             pop;
      data_req_i   = req;
      data_we_i    = we;
      data_addr_i  = addr;
      data_wdata_i = wd;
      data_be_i    = be;
      slv_rvalid_i = rv;
      slv_rdata_i  = rd;
      #3;
      tgt    = ref_decode(addr);
      e_gnt  = req && (mq.size() < MAX_OUTST);
      e_sreq = '0;
      if (e_gnt && tgt != MISS) e_sreq[tgt] = 1'b1;
      chk("gnt", 64'(data_gnt_o), 64'(e_gnt));
      chk("slv_req", 64'(slv_req_o), 64'(e_sreq));
      chk("slv_addr", 64'(slv_addr_o), 64'(addr));
      chk("slv_payload", 64'({slv_we_o, slv_be_o, slv_wdata_o}), 64'({we, be, wd}));
      obs_gnt  = data_gnt_o;
      obs_sreq = slv_req_o;

      pop      = 1'b0;
      e_rvalid = 1'b0;
      for (int j = 0; j < N_SLV; j++) begin
         if (rv[j] && (mq.size() == 0 || mq[0] != j)) e_proto = 1'b1;
      end
      if (mq.size() != 0) begin
         if (mq[0] == MISS) begin
            pop = 1'b1; e_rvalid = 1'b1; e_rdata = '0; e_err = 1'b1;
         end else if (rv[mq[0]]) begin
            pop = 1'b1; e_rvalid = 1'b1; e_rdata = rd[mq[0]*DW +: DW]; e_err = 1'b0;
         end
`ifdef DBUS_TIMEOUT_EN
         else if (wdog + 1 == TIMEOUT_CYC) begin
            pop = 1'b1; e_rvalid = 1'b1; e_rdata = '0; e_err = 1'b1;
         end else begin
            wdog++;
         end
`endif
      end
`ifdef DBUS_TIMEOUT_EN
      if (pop || mq.size() == 0) wdog = 0;
`endif
      if (pop) void'(mq.pop_front());
      if (e_gnt) mq.push_back(tgt);

      @(posedge clk_i);
      #1;
      chk("rvalid", 64'(data_rvalid_o), 64'(e_rvalid));
      chk("rdata", 64'(data_rdata_o), 64'(e_rdata));
      chk("err", 64'(data_err_o), 64'(e_err));
      chk("outst", 64'(outst_o), 64'(mq.size()));
      chk("proto", 64'(proto_err_o), 64'(e_proto));
      obs_rvalid = data_rvalid_o;
      obs_rdata  = data_rdata_o;
      obs_err    = data_err_o;
      obs_proto  = proto_err_o;
      obs_outst  = outst_o;
   endtask

   task automatic idle();
      run_cycle(1'b0, 1'b0, '0, '0, '0, '0, '0);
   endtask

   task automatic do_reset();
      rst_i        = 1'b1;
      data_req_i   = 1'b0;
      data_we_i    = 1'b0;
      data_be_i    = '0;
      data_addr_i  = '0;
      data_wdata_i = '0;
      slv_rvalid_i = '0;
      slv_rdata_i  = '0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      mq.delete();
      e_rvalid = 1'b0;
      e_rdata  = '0;
      e_err    = 1'b0;
      e_proto  = 1'b0;
`ifdef DBUS_TIMEOUT_EN
      wdog = 0;
`endif
      chk("rst_rvalid", 64'(data_rvalid_o), 64'(0));
      chk("rst_rdata", 64'(data_rdata_o), 64'(0));
      chk("rst_err", 64'(data_err_o), 64'(0));
      chk("rst_outst", 64'(outst_o), 64'(0));
      chk("rst_proto", 64'(proto_err_o), 64'(0));
   endtask

   initial begin
      tbl[0]  = '{32'h0000_4000, 1'b0, 3'b001};
      tbl[1]  = '{32'h0000_0010, 1'b1, 3'b000};
      tbl[2]  = '{32'h0000_7FFC, 1'b0, 3'b001};
      tbl[3]  = '{32'h0000_7FFF, 1'b1, 3'b001};
      tbl[4]  = '{32'h0000_8000, 1'b0, 3'b010};
      tbl[5]  = '{32'h0000_800B, 1'b0, 3'b010};
      tbl[6]  = '{32'h0000_800C, 1'b1, 3'b100};
      tbl[7]  = '{32'h0000_801F, 1'b0, 3'b100};
      tbl[8]  = '{32'h0000_8020, 1'b0, 3'b000};
      tbl[9]  = '{32'h0000_3FFF, 1'b0, 3'b000};
      tbl[10] = '{32'hFFFF_FFFF, 1'b1, 3'b000};
      tbl[11] = '{32'h0000_0000, 1'b0, 3'b000};

      do_reset();

      // decode table: accept, one-cycle slave answer, response at accept+2
      for (int i = 0; i < 12; i++) begin
         logic [DW-1:0]       dat;
         logic [N_SLV*DW-1:0] rd;
         dat = 32'hDEAD_BEEF + 32'(i);
         rd  = '0;
         for (int k = 0; k < N_SLV; k++) begin
            if (tbl[i].exp_req[k]) rd[k*DW +: DW] = dat;
         end
         run_cycle(1'b1, tbl[i].we, tbl[i].addr, 32'h5555_0000 + 32'(i), 4'hF, '0, '0);
         chk("tbl_gnt", 64'(obs_gnt), 64'(1));
         chk("tbl_req", 64'(obs_sreq), 64'(tbl[i].exp_req));
         chk("tbl_lat1", 64'(obs_rvalid), 64'(0));
         run_cycle(1'b0, 1'b0, '0, '0, '0, tbl[i].exp_req, rd);
         chk("tbl_rvalid", 64'(obs_rvalid), 64'(1));
         chk("tbl_rdata", 64'(obs_rdata), (tbl[i].exp_req == '0) ? 64'(0) : 64'(dat));
         chk("tbl_err", 64'(obs_err), (tbl[i].exp_req == '0) ? 64'(1) : 64'(0));
         idle();
         chk("tbl_rv_low", 64'(obs_rvalid), 64'(0));
      end

      // back-to-back reads with stalled slave: FIFO fills, order preserved
      begin : t_full
         int                  acc, served, got;
         logic                req, was_full;
         logic [N_SLV-1:0]    rv;
         logic [N_SLV*DW-1:0] rd;
         acc = 0; served = 0; got = 0;
         for (int c = 0; c < 24; c++) begin
            req = (acc < 4);
            rv  = '0;
            rd  = '0;
            if (c >= 5 && mq.size() != 0 && mq[0] == 0) begin
               rv[0] = 1'b1;
               rd[DW-1:0] = 32'hA000_0000 + 32'(served);
               served++;
            end
            was_full = (mq.size() == MAX_OUTST);
            run_cycle(req, 1'b0, 32'h4000 + 32'(4 * acc), '0, 4'hF, rv, rd);
            if (req && was_full) chk("full_gnt", 64'(obs_gnt), 64'(0));
            if (req && obs_gnt) acc++;
            if (c == 4) chk("full_outst", 64'(obs_outst), 64'(2));
            if (obs_rvalid) begin
               chk("order", 64'(obs_rdata), 64'(32'hA000_0000 + 32'(got)));
               got++;
            end
         end
         chk("all_done", 64'(got), 64'(4));
         chk("drained", 64'(obs_outst), 64'(0));
      end

      // response from a slave while the FIFO is empty
      do_reset();
      run_cycle(1'b0, 1'b0, '0, '0, '0, 3'b010, {3{32'h1111_1111}});
      chk("viol_empty_rv", 64'(obs_rvalid), 64'(0));
      chk("viol_empty_flag", 64'(obs_proto), 64'(1));

      // wrong slave answers while slave0 is head
      do_reset();
      run_cycle(1'b1, 1'b0, 32'h4000, '0, 4'hF, '0, '0);
      run_cycle(1'b0, 1'b0, '0, '0, '0, 3'b100, {32'hBAD0_0002, 64'h0});
      chk("viol_rvalid", 64'(obs_rvalid), 64'(0));
      chk("viol_flag", 64'(obs_proto), 64'(1));
      repeat (3) idle();
      chk("viol_sticky", 64'(obs_proto), 64'(1));
      chk("viol_outst", 64'(obs_outst), 64'(1));
      run_cycle(1'b0, 1'b0, '0, '0, '0, 3'b001, {64'h0, 32'h1234_5678});
      chk("viol_recover", 64'(obs_rvalid), 64'(1));
      chk("viol_rdata", 64'(obs_rdata), 64'(32'h1234_5678));
      chk("viol_still", 64'(obs_proto), 64'(1));

      // silent slave1
      do_reset();
      begin : t_silent
         int nresp, at;
         nresp = 0; at = -1;
         run_cycle(1'b1, 1'b0, 32'h8000, '0, 4'hF, '0, '0);
         for (int i = 0; i < 1000; i++) begin
            idle();
            if (obs_rvalid) begin
               nresp++;
               at = i;
            end
         end
`ifdef DBUS_TIMEOUT_EN
         chk("tmo_count", 64'(nresp), 64'(1));
         chk("tmo_cycle", 64'(at), 64'(TIMEOUT_CYC - 1));
         chk("tmo_err", 64'(obs_err), 64'(1));
         chk("tmo_outst", 64'(obs_outst), 64'(0));
         run_cycle(1'b0, 1'b0, '0, '0, '0, 3'b010, '0);
         chk("tmo_late", 64'(obs_proto), 64'(1));
`else
         chk("wait_count", 64'(nresp), 64'(0));
         chk("wait_at", 64'(at), 64'(-1));
         chk("wait_outst", 64'(obs_outst), 64'(1));
`endif
      end

      // randomized legal traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         int                  r, k;
         logic [AW-1:0]       a;
         logic [N_SLV-1:0]    rv;
         logic [N_SLV*DW-1:0] rd;
         r = int'($urandom_range(0, 5));
         k = int'($urandom_range(0, N_SLV - 1));
         case (r)
            0, 1, 2: a = BASE[k] + ($urandom % SIZE[k]);
            3:       a = BASE[k] + SIZE[k] - 32'd1;
            4:       a = $urandom;
            default: a = BASE[k] - 32'd1 + 32'(k == 2) * 32'd21;
         endcase
         rv = '0;
         if (mq.size() != 0 && mq[0] != MISS && $urandom_range(0, 2) != 0) rv[mq[0]] = 1'b1;
         rd = {$urandom, $urandom, $urandom};
         run_cycle($urandom_range(0, 9) < 6, 1'($urandom), a, $urandom, 4'($urandom), rv, rd);
      end

      // mid-operation reset drops everything
      run_cycle(1'b1, 1'b0, 32'h4000, '0, 4'hF, '0, '0);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
